booth_mult_r4: RTL and testbench

- Parametrised sequential radix-4 (modified Booth) multiplier. Successor to the radix-2 filter multiplier.
- Adds:
  - signed/unsigned operand mode, selected per transaction;
  - valid/ready handshakes on input and output;
  - synchronous reset;
  - half the iteration count of radix-2.
- Sits in the FILTER datapath between coefficient/sample registers and the accumulator.

---
 rtl/booth_mult_r4_pkg.sv | 27 ++
 rtl/booth_mult_r4_if.sv | 40 ++++
 rtl/booth_mult_r4_enc.sv | 42 ++++
 rtl/booth_mult_r4.sv | 161 ++++++++++++++++
 tb/tb_booth_mult_r4.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_mult_r4_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
//   state_t      : controller states (2-bit; code 2'b11 unused)
//   booth_dig_t  : recoded Booth digit {0, +A, +2A, -A, -2A}
//   calc_w(m)    : extended operand width, m+2 rounded up to even
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_dig_t;

    // Two guard bits let an unsigned M-bit operand stay positive in
    // signed arithmetic; rounding to even gives whole Booth triplets.
    function automatic int calc_w(input int m);
        return ((m + 3) / 2) * 2;
    endfunction

endpackage

// File: rtl/booth_mult_r4_if.sv
// Operand/result bus of booth_mult_r4.
// Handshake rule: a transfer happens on a rising clk edge where valid
// and ready are both high; valid never waits on ready, and the payload
// is held stable while valid is high and ready is low.
//   in_valid/in_ready   : operand channel (a, b, signed_mode)
//   out_valid/out_ready : result channel (prod, prod_rnd if MULT_ROUND_EN)
//   busy                : block is in CALC or DONE
// Optional build macro: MULT_ROUND_EN adds the prod_rnd signal.
interface booth_mult_r4_if #(parameter int M = 12);

    logic           in_valid;
    logic           in_ready;
    logic [M-1:0]   a;
    logic [M-1:0]   b;
    logic           signed_mode;
    logic           out_valid;
    logic           out_ready;
    logic [2*M-1:0] prod;
    logic           busy;
`ifdef MULT_ROUND_EN
    logic [M-1:0]   prod_rnd;
`endif

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, prod, busy
`ifdef MULT_ROUND_EN
        , input prod_rnd
`endif
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, prod, busy
`ifdef MULT_ROUND_EN
        , output prod_rnd
`endif
    );

endinterface

// File: rtl/booth_mult_r4_enc.sv
// booth_r4_enc: combinational radix-4 Booth recoder.
//   trip   in  3    multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//   a_ext  in  W    extended multiplicand (two's complement)
//   addend out W+2  selected term {0, +A, +2A, -A, -2A}, sign-extended
module booth_r4_enc
    import mult_pkg::*;
#(
    parameter int W = 14
) (
    input  logic [2:0]   trip,
    input  logic [W-1:0] a_ext,
    output logic [W+1:0] addend
);

    booth_dig_t   digit;
    logic [W+1:0] a_sx;

    assign a_sx = {{2{a_ext[W-1]}}, a_ext};

    always_comb begin
        digit = ZERO;
        case (trip)
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
    end

    always_comb begin
        addend = '0;
        case (digit)
            P1:      addend = a_sx;
            P2:      addend = a_sx << 1;
            M1:      addend = -a_sx;
            M2:      addend = -(a_sx << 1);
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_r4.sv
// booth_mult_r4: sequential radix-4 (modified Booth) multiplier, M-bit
// operands, signed or unsigned per transaction, N = W/2 iterations.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   bus        slave modport of booth_mult_r4_if (handshakes, a, b,
//              signed_mode, prod, busy, prod_rnd)
//   dbg_state  out  current controller state
// Optional build macro: MULT_ROUND_EN adds prod_rnd, the Q-format
// rounded/saturated M-bit result, registered alongside prod.
module booth_mult_r4
    import mult_pkg::*;
#(
    parameter int M = 12
) (
    input  logic           clk,
    input  logic           rst,
    booth_mult_r4_if.slave bus,
    output state_t         dbg_state
);

    localparam int W  = calc_w(M);
    localparam int N  = W / 2;
    localparam int CW = $clog2(N + 1);

    state_t state, state_nx;
    logic   ld, step, clr, last;
    logic   in_ready_c, out_valid_c, busy_c;

    // Partial product {hi, lo, g}: hi accumulates, lo holds the
    // multiplier being shifted out, g is the b[-1] guard bit.
    logic [W-1:0]   a_ext, hi, lo;
    logic           g;
    logic [CW-1:0]  cnt;
    logic [W+1:0]   addend, sum;
    logic [W-1:0]   hi_nx, lo_nx;
    logic [2*M-1:0] prod_q, prod_nx;

    booth_r4_enc #(.W(W)) u_enc (
        .trip   ({lo[1:0], g}),
        .a_ext  (a_ext),
        .addend (addend)
    );

    assign sum   = {{2{hi[W-1]}}, hi} + addend;
    // Arithmetic shift by 2: the running sum always fits back into W bits.
    assign hi_nx = sum[W+1:2];
    assign lo_nx = {sum[1:0], lo[W-1:2]};
    assign prod_nx = (2*M)'({hi_nx, lo_nx});
    assign last    = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b0;
        ld          = 1'b0;
        step        = 1'b0;
        clr         = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    ld       = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                busy_c = 1'b1;
                step   = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: begin
                // Unused code: behave like reset for one cycle.
                clr      = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

`ifdef MULT_ROUND_EN
    localparam logic signed [2*M+1:0] RND_HALF = (2*M+2)'(1) << (M - 2);
    localparam logic signed [2*M+1:0] S_MAX    = ((2*M+2)'(1) << (M - 1)) - 1;
    localparam logic signed [2*M+1:0] S_MIN    = -((2*M+2)'(1) << (M - 1));
    localparam logic signed [2*M+1:0] U_MAX    = ((2*M+2)'(1) << M) - 1;

    logic         sm_q;
    logic [M-1:0] rnd_q;

    // Add half an LSB of the Q(M-1) result, floor by shifting (ties go
    // toward +inf), then clamp to the M-bit range of the operand mode.
    function automatic logic [M-1:0] round_sat(input logic [2*M-1:0] p,
                                               input logic sm);
        logic signed [2*M+1:0] ext;
        logic signed [2*M+1:0] sh;
        ext = sm ? $signed({{2{p[2*M-1]}}, p}) : $signed({2'b00, p});
        sh  = (ext + RND_HALF) >>> (M - 1);
        if (sm) begin
            if (sh > S_MAX)      return M'(S_MAX);
            else if (sh < S_MIN) return M'(S_MIN);
            else                 return M'(sh);
        end else begin
            if (sh > U_MAX)      return M'(U_MAX);
            else                 return M'(sh);
        end
    endfunction

    assign bus.prod_rnd = rnd_q;
`endif

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_ext  <= '0;
            hi     <= '0;
            lo     <= '0;
            g      <= 1'b0;
            cnt    <= '0;
            prod_q <= '0;
`ifdef MULT_ROUND_EN
            sm_q   <= 1'b0;
            rnd_q  <= '0;
`endif
        end else if (ld) begin
            a_ext <= {{(W-M){bus.signed_mode & bus.a[M-1]}}, bus.a};
            lo    <= {{(W-M){bus.signed_mode & bus.b[M-1]}}, bus.b};
            hi    <= '0;
            g     <= 1'b0;
            cnt   <= '0;
`ifdef MULT_ROUND_EN
            sm_q  <= bus.signed_mode;
`endif
        end else if (step) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            g   <= lo[1];
            cnt <= cnt + 1'b1;
            if (last) begin
                prod_q <= prod_nx;
`ifdef MULT_ROUND_EN
                rnd_q  <= round_sat(prod_nx, sm_q);
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
    assign bus.prod      = prod_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_booth_mult_r4.sv
module tb_booth_mult_r4;
    import mult_pkg::*;

    localparam int M = 12;
    localparam int N = 7;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    logic [2*M-1:0] exp_q[$];
    int             acc_cyc[$];
    logic [2*M-1:0] sb_exp;
`ifdef MULT_ROUND_EN
    logic [M-1:0]   exp_r_q[$];
    logic [M-1:0]   sb_exp_r;
`endif

    booth_mult_r4_if #(.M(M)) bus ();

    booth_mult_r4 #(.M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint op_val(input logic [M-1:0] v, input logic sm);
        if (sm) return longint'($signed(v));
        else    return longint'(v);
    endfunction

    function automatic logic [2*M-1:0] ref_prod(input logic [M-1:0] ra,
                                                input logic [M-1:0] rb,
                                                input logic sm);
        longint p;
        p = op_val(ra, sm) * op_val(rb, sm);
        return (2*M)'(p);
    endfunction

`ifdef MULT_ROUND_EN
    function automatic logic [M-1:0] ref_rnd(input logic [M-1:0] ra,
                                             input logic [M-1:0] rb,
                                             input logic sm);
        longint p, q, hi_lim, lo_lim;
        p = op_val(ra, sm) * op_val(rb, sm);
        q = (p + (longint'(1) << (M - 2))) >>> (M - 1);
        hi_lim = sm ? (longint'(1) << (M - 1)) - 1 : (longint'(1) << M) - 1;
        lo_lim = sm ? -(longint'(1) << (M - 1)) : 0;
        if (q > hi_lim) q = hi_lim;
        if (q < lo_lim) q = lo_lim;
        return M'(q);
    endfunction
`endif

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_prod(bus.a, bus.b, bus.signed_mode));
                acc_cyc.push_back(cyc);
`ifdef MULT_ROUND_EN
                exp_r_q.push_back(ref_rnd(bus.a, bus.b, bus.signed_mode));
`endif
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=0x%0h required=no_output", bus.prod);
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("sb_prod", 64'(bus.prod), 64'(sb_exp));
`ifdef MULT_ROUND_EN
                    sb_exp_r = exp_r_q.pop_front();
                    check("sb_prod_rnd", 64'(bus.prod_rnd), 64'(sb_exp_r));
`endif
                end
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    task automatic run_txn(input logic [M-1:0] ta, input logic [M-1:0] tb_v,
                           input logic tsm, input int hold,
                           output logic [2*M-1:0] got, output int lat);
        logic [2*M-1:0] want;
        int k;
        want = ref_prod(ta, tb_v, tsm);
        got  = '0;
        lat  = -1;
        @(posedge clk); #1;
        bus.a = ta; bus.b = tb_v; bus.signed_mode = tsm;
        bus.in_valid = 1'b1; bus.out_ready = (hold == 0);
        @(negedge clk);
        k = 0;
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        if (!bus.in_ready) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // Operands change after acceptance; the result must not follow.
        bus.in_valid = 1'b0;
        bus.a = M'($urandom); bus.b = M'($urandom); bus.signed_mode = 1'($urandom);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("calc_busy", 64'(bus.busy), 64'd1);
                check("calc_in_ready", 64'(bus.in_ready), 64'd0);
            end
            if (bus.out_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", 64'(lat), 64'(N + 1));
        if (lat < 0) return;
        got = bus.prod;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            bus.a = M'($urandom); bus.b = M'($urandom); bus.in_valid = 1'b1;
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_prod", 64'(bus.prod), 64'(want));
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0; bus.out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("in_ready_back", 64'(bus.in_ready), 64'd1);
        check("prod_held", 64'(bus.prod), 64'(want));
    endtask

    typedef struct {
        logic [M-1:0]   a;
        logic [M-1:0]   b;
        logic           sm;
        int             hold;
        logic [2*M-1:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [2*M-1:0] got;
        int lat;
        logic ov_seen;

        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;

        vecs[0] = '{12'd5,   12'd7,   1'b0, 0, 24'h000023};
        vecs[1] = '{12'hFFF, 12'hFFF, 1'b0, 0, 24'hFFE001};
        vecs[2] = '{12'hFFF, 12'hFFF, 1'b1, 0, 24'h000001};
        vecs[3] = '{12'h800, 12'h800, 1'b1, 0, 24'h400000};
        vecs[4] = '{12'h800, 12'h7FF, 1'b1, 0, 24'hC00800};
        vecs[5] = '{12'h7FF, 12'h800, 1'b0, 5, 24'h3FF800};
        vecs[6] = '{12'h000, 12'hABC, 1'b1, 0, 24'h000000};
        vecs[7] = '{12'hFFD, 12'h006, 1'b1, 2, 24'hFFFFEE};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_prod", 64'(bus.prod), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].hold, got, lat);
            check($sformatf("vec%0d_prod", i), 64'(got), 64'(vecs[i].exp));
        end

        // Reset in the middle of CALC
        @(posedge clk); #1;
        bus.a = 12'd9; bus.b = 12'd9; bus.signed_mode = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        check("rm_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rm_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
`ifdef MULT_ROUND_EN
        exp_r_q.delete();
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rm_in_ready_after", 64'(bus.in_ready), 64'd1);
        check("rm_busy_after", 64'(bus.busy), 64'd0);
        check("rm_prod_cleared", 64'(bus.prod), 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ov_seen = ov_seen | bus.out_valid;
        end
        check("rm_no_output", 64'(ov_seen), 64'd0);
        run_txn(12'd3, 12'd4, 1'b0, 0, got, lat);
        check("rm_next_prod", 64'(got), 64'd12);

`ifdef MULT_ROUND_EN
        run_txn(12'h400, 12'h400, 1'b1, 0, got, lat);
        check("rnd_half", 64'(bus.prod_rnd), 64'h200);
        run_txn(12'h800, 12'h800, 1'b1, 0, got, lat);
        check("rnd_sat", 64'(bus.prod_rnd), 64'h7FF);
`endif

        // Throughput: in_valid and out_ready held high
        acc_cyc.delete();
        @(posedge clk); #1;
        bus.out_ready = 1'b1; bus.in_valid = 1'b1;
        for (int i = 0; i < 3 * (N + 2) + 1; i++) begin
            bus.a = M'($urandom); bus.b = M'($urandom); bus.signed_mode = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (2 * (N + 2)) @(posedge clk);
        check("tp_accepts", 64'(acc_cyc.size()), 64'd4);
        for (int i = 0; i + 1 < acc_cyc.size(); i++)
            check("tp_gap", 64'(acc_cyc[i+1] - acc_cyc[i]), 64'(N + 2));

        // Randomized transactions against the model
        for (int i = 0; i < 40; i++)
            run_txn(M'($urandom), M'($urandom), 1'($urandom),
                    $urandom_range(0, 2), got, lat);

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
